// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: forward-select codes, FSM state encoding and the XZR register index
package pipeline_hazard_ctrl_pkg;
  localparam int XZR = 31;
  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB = 2'b01;
  typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_FLUSH} state_t;
endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_fwd_unit.sv
// pipeline_hazard_ctrl_hazard_fwd_unit: combinational register-match hazard detect and forward select
// HAZARD_FWD_EN selects forwarding with load-use-only stalls; otherwise any match stalls with a wait count
module pipeline_hazard_ctrl_hazard_fwd_unit
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter logic [REG_ADDR_W-1:0] ZERO_REG = REG_ADDR_W'(XZR)
) (
  input  logic [REG_ADDR_W-1:0] id_rn,
  input  logic [REG_ADDR_W-1:0] id_rm,
  input  logic                  id_uses_rm,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  output logic                  hazard,
  output logic [1:0]            wait_init,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b
);
  logic rn_ex, rn_mem, rn_wb, rm_ex, rm_mem, rm_wb;
  assign rn_ex = id_rn != ZERO_REG && ex_reg_write && id_rn == ex_rd;
  assign rn_mem = id_rn != ZERO_REG && mem_reg_write && id_rn == mem_rd;
  assign rn_wb = id_rn != ZERO_REG && wb_reg_write && id_rn == wb_rd;
  assign rm_ex = id_uses_rm && id_rm != ZERO_REG && ex_reg_write && id_rm == ex_rd;
  assign rm_mem = id_uses_rm && id_rm != ZERO_REG && mem_reg_write && id_rm == mem_rd;
  assign rm_wb = id_uses_rm && id_rm != ZERO_REG && wb_reg_write && id_rm == wb_rd;
`ifdef HAZARD_FWD_EN
  // The writeback stage writes the regfile in the same cycle, so it never needs a forward.
  logic unused_wb;
  assign unused_wb = rn_wb | rm_wb;
  assign hazard = ex_mem_read && (rn_ex || rm_ex);
  assign wait_init = 2'd1;
  assign fwd_a = rn_ex ? FWD_MEM : rn_mem ? FWD_WB : FWD_REGFILE;
  assign fwd_b = rm_ex ? FWD_MEM : rm_mem ? FWD_WB : FWD_REGFILE;
`else
  logic unused_ld;
  assign unused_ld = ex_mem_read;
  assign wait_init = (rn_ex || rm_ex) ? 2'd3 : (rn_mem || rm_mem) ? 2'd2 : (rn_wb || rm_wb) ? 2'd1 : 2'd0;
  assign hazard = wait_init != 2'd0;
  assign fwd_a = FWD_REGFILE;
  assign fwd_b = FWD_REGFILE;
`endif
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: 5-stage pipeline stall/flush sequencer with forward selects and perf counters
// Optional forwarding build via macro HAZARD_FWD_EN
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter logic [REG_ADDR_W-1:0] ZERO_REG = REG_ADDR_W'(XZR),
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rn,
  input  logic [REG_ADDR_W-1:0] id_rm,
  input  logic                  id_uses_rm,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  input  logic                  pc_src,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  idex_bubble,
  output logic                  flush,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);
  state_t state, state_nxt;
  logic [1:0] wait_cnt, wait_nxt, wait_init, fa, fb;
  logic hazard, hold, stall_req, stall;
  pipeline_hazard_ctrl_hazard_fwd_unit #(.REG_ADDR_W(REG_ADDR_W), .ZERO_REG(ZERO_REG)) u_hfu (
    .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .hazard(hazard), .wait_init(wait_init), .fwd_a(fa), .fwd_b(fb)
  );
`ifdef HAZARD_FWD_EN
  assign hold = hazard;
`else
  assign hold = wait_cnt != 2'd0;
`endif
  always_comb begin
    stall_req = state == ST_RUN ? hazard : state == ST_STALL ? hold : 1'b0;
    state_nxt = pc_src ? ST_FLUSH : stall_req ? ST_STALL : ST_RUN;
    wait_nxt = pc_src ? 2'd0 : state == ST_RUN ? (hazard ? wait_init - 2'd1 : 2'd0) :
               (wait_cnt != 2'd0 ? wait_cnt - 2'd1 : 2'd0);
  end
  // Outputs fall back to their reset values while reset is held, regardless of inputs.
  assign stall = reset && !pc_src && stall_req;
  assign flush = reset && pc_src;
  assign pc_write = !stall;
  assign ifid_write = !stall;
  assign idex_bubble = stall || flush;
  assign fwd_a = reset ? fa : FWD_REGFILE;
  assign fwd_b = reset ? fb : FWD_REGFILE;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_RUN;
      wait_cnt <= 2'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      wait_cnt <= wait_nxt;
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (flush && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of stall, flush, forward and reset behaviour (either HAZARD_FWD_EN build)
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] id_rn, id_rm, ex_rd, mem_rd, wb_rd;
  logic id_uses_rm, ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write, pc_src;
  logic pc_write, ifid_write, idex_bubble, flush;
  logic [1:0] fwd_a, fwd_b;
  logic [31:0] stall_cnt, flush_cnt;
  int vec = 0;
  int errs = 0;
  int sc;
  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .pc_src(pc_src), .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
    .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle();
    id_rn = 5'd0; id_rm = 5'd0; id_uses_rm = 1'b0;
    ex_rd = 5'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    mem_rd = 5'd0; mem_reg_write = 1'b0;
    wb_rd = 5'd0; wb_reg_write = 1'b0; pc_src = 1'b0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    idle();
    #2;
    chk("reset_pc_write", pc_write, 1);
    chk("reset_ifid_write", ifid_write, 1);
    chk("reset_bubble", idex_bubble, 0);
    chk("reset_flush", flush, 0);
    chk("reset_fwd", {fwd_a, fwd_b}, 0);
    chk("reset_stall_cnt", stall_cnt, 0);
    chk("reset_flush_cnt", flush_cnt, 0);
    #6 reset = 1'b1;
    tick();
`ifdef HAZARD_FWD_EN
    ex_rd = 5'd1; ex_reg_write = 1'b1; ex_mem_read = 1'b1; id_rn = 5'd1; id_rm = 5'd4; id_uses_rm = 1'b1;
    #2;
    chk("ld_use_pc_write", pc_write, 0);
    chk("ld_use_bubble", idex_bubble, 1);
    tick();
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; mem_rd = 5'd1; mem_reg_write = 1'b1;
    #2;
    chk("ld_use_release", pc_write, 1);
    chk("ld_use_fwd_a", fwd_a, 2'b01);
    chk("ld_use_stall_cnt", stall_cnt, 1);
    tick();
    idle();
    ex_rd = 5'd1; ex_reg_write = 1'b1; id_rn = 5'd1; id_rm = 5'd1; id_uses_rm = 1'b1;
    #2;
    chk("raw_no_stall", pc_write, 1);
    chk("raw_fwd_ab", {fwd_a, fwd_b}, 4'b1010);
    ex_rd = 5'd31; id_rn = 5'd31; id_rm = 5'd31;
    #2;
    chk("xzr_fwd_ab", {fwd_a, fwd_b}, 4'b0000);
    ex_rd = 5'd7; mem_rd = 5'd7; mem_reg_write = 1'b1; id_rn = 5'd7; id_uses_rm = 1'b0;
    #2;
    chk("mem_wins_fwd_a", fwd_a, 2'b10);
    chk("no_rm_fwd_b", fwd_b, 2'b00);
    sc = 1;
`else
    ex_rd = 5'd1; ex_reg_write = 1'b1; id_rn = 5'd1; id_rm = 5'd1; id_uses_rm = 1'b1;
    #2;
    chk("raw_ex_pc_write", pc_write, 0);
    chk("raw_ex_bubble", idex_bubble, 1);
    chk("raw_ex_fwd", {fwd_a, fwd_b}, 0);
    tick();
    ex_reg_write = 1'b0; mem_rd = 5'd1; mem_reg_write = 1'b1;
    #2;
    chk("raw_stall2", pc_write, 0);
    tick();
    mem_reg_write = 1'b0; wb_rd = 5'd1; wb_reg_write = 1'b1;
    #2;
    chk("raw_stall3", ifid_write, 0);
    tick();
    wb_reg_write = 1'b0;
    #2;
    chk("raw_release", pc_write, 1);
    chk("raw_stall_cnt", stall_cnt, 3);
    tick();
    idle();
    mem_rd = 5'd9; mem_reg_write = 1'b1; id_rm = 5'd9; id_uses_rm = 1'b1;
    #2;
    chk("mem_hit_stall", pc_write, 0);
    tick();
    mem_reg_write = 1'b0; wb_rd = 5'd9; wb_reg_write = 1'b1;
    #2;
    chk("mem_hit_stall2", pc_write, 0);
    tick();
    idle();
    #2;
    chk("mem_hit_release", pc_write, 1);
    chk("mem_hit_stall_cnt", stall_cnt, 5);
    tick();
    wb_rd = 5'd4; wb_reg_write = 1'b1; id_rn = 5'd4;
    #2;
    chk("wb_hit_stall", pc_write, 0);
    tick();
    idle();
    #2;
    chk("wb_hit_release", pc_write, 1);
    tick();
    chk("wb_hit_stall_cnt", stall_cnt, 6);
    ex_rd = 5'd31; ex_reg_write = 1'b1; id_rn = 5'd31;
    #2;
    chk("xzr_no_stall", pc_write, 1);
    ex_rd = 5'd2; id_rn = 5'd0; id_rm = 5'd2; id_uses_rm = 1'b0;
    #2;
    chk("rm_unused_no_stall", pc_write, 1);
    tick();
    idle();
    sc = 6;
`endif
    tick();
    idle();
    ex_rd = 5'd3; ex_reg_write = 1'b1; ex_mem_read = 1'b1; id_rn = 5'd3;
    #2;
    chk("pre_flush_stall", pc_write, 0);
    tick();
    pc_src = 1'b1;
    #2;
    chk("flush_in_stall", flush, 1);
    chk("flush_pc_write", pc_write, 1);
    chk("flush_bubble", idex_bubble, 1);
    tick();
    pc_src = 1'b0;
    #2;
    chk("flush_state_masked", pc_write, 1);
    chk("flush_state_no_flush", flush, 0);
    chk("flush_cnt", flush_cnt, 1);
    chk("flush_stall_cnt", stall_cnt, sc + 1);
    tick();
    #2;
    chk("run_after_flush", pc_write, 0);
    tick();
    #2;
    chk("stall_before_reset", pc_write, 0);
    chk("stall_cnt_before_reset", stall_cnt, sc + 2);
    reset = 1'b0;
    #1;
    chk("async_pc_write", pc_write, 1);
    chk("async_bubble", idex_bubble, 0);
    chk("async_stall_cnt", stall_cnt, 0);
    chk("async_flush_cnt", flush_cnt, 0);
    @(negedge clk);
    reset = 1'b1;
    idle();
    tick();
    #2;
    chk("post_reset_run", pc_write, 1);
    chk("post_reset_cnt", stall_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
